hex_seg_scanner: RTL and testbench

Time-multiplexed seven-segment driver that consumes six 4-bit digit codes (d0..d5) from upstream digit producers such as the blink and reaction-timer counters and drives the six HEX displays. One shared code-to-segment decoder is sequenced across the digits, one digit per clock. All six inputs are snapshotted at the start of each frame, so every displayed frame is coherent. Code 4'hF is the blank code, so a producer blanks a digit by driving 4'b1111.

---
 rtl/hex_seg_scanner.sv | 122 ++++++++++++
 tb/tb_hex_seg_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_seg_scanner.sv
// Six-digit time-multiplexed seven-segment driver: one shared decoder walks the
// digits one per clock, from a snapshot of all six codes taken at the start of each frame.
module hex_seg_scanner #(
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic       ms_clk,
  input  logic       Reset_n,
  input  logic       enable,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    PH_SNAP = 3'd0,
    PH_D0   = 3'd1,
    PH_D1   = 3'd2,
    PH_D2   = 3'd3,
    PH_D3   = 3'd4,
    PH_D4   = 3'd5,
    PH_D5   = 3'd6
  } phase_e;

  phase_e           ph_q, ph_d;
  logic [2:0]       ph_bits;
  logic [5:0][3:0]  snap_q, snap_d;
  logic [5:0][6:0]  hex_q, hex_d;
  logic             frame_done_q, frame_done_d;
  logic [5:0]       lead;
  logic [5:0]       supp;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic is_empty(input logic [3:0] c);
    return (c == 4'h0) || (c == 4'hF);
  endfunction

  assign ph_bits = ph_q;

  // lead[k] is set when snap[k..5] are all zero-or-blank; d0 is never suppressed.
  always_comb begin
    lead    = '0;
    lead[5] = is_empty(snap_q[5]);
    for (int unsigned i = 1; i < 6; i++) begin
      lead[5 - i] = lead[6 - i] & is_empty(snap_q[5 - i]);
    end
    supp = LZ_SUPPRESS ? (lead & 6'b111110) : '0;
  end

  always_comb begin
    ph_d         = ph_q;
    snap_d       = snap_q;
    hex_d        = hex_q;
    frame_done_d = 1'b0;
    if (enable) begin
      if (ph_q == PH_SNAP) begin
        snap_d = {d5, d4, d3, d2, d1, d0};
        ph_d   = PH_D0;
      end else begin
        for (int unsigned i = 0; i < 6; i++) begin
          if (ph_bits == 3'(i + 1)) begin
            hex_d[i] = supp[i] ? 7'h7F : decode(snap_q[i]);
          end
        end
        ph_d         = (ph_q == PH_D5) ? PH_SNAP : phase_e'(ph_bits + 3'd1);
        frame_done_d = (ph_q == PH_D5);
      end
    end
  end

  always_ff @(posedge ms_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ph_q         <= PH_SNAP;
      snap_q       <= '1;
      hex_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      ph_q         <= ph_d;
      snap_q       <= snap_d;
      hex_q        <= hex_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign HEX0       = hex_q[0];
  assign HEX1       = hex_q[1];
  assign HEX2       = hex_q[2];
  assign HEX3       = hex_q[3];
  assign HEX4       = hex_q[4];
  assign HEX5       = hex_q[5];
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_seg_scanner.sv
// Scoreboard bench for hex_seg_scanner: one instance without and one with
// leading-zero suppression, driven in lockstep from the same inputs.
module tb_hex_seg_scanner;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
  localparam logic [6:0] S8 = 7'h00, S9 = 7'h10, SA = 7'h08, SB = 7'h03;
  localparam logic [6:0] SC = 7'h46, SD = 7'h21, SE = 7'h06, BL = 7'h7F;
  localparam logic [41:0] ALL_BL = {BL, BL, BL, BL, BL, BL};

  logic       ms_clk;
  logic       Reset_n;
  logic       enable;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic [6:0] ha0, ha1, ha2, ha3, ha4, ha5;
  logic [6:0] hb0, hb1, hb2, hb3, hb4, hb5;
  logic       fd_a, fd_b;
  logic [41:0] hx_a, hx_b;

  assign hx_a = {ha5, ha4, ha3, ha2, ha1, ha0};
  assign hx_b = {hb5, hb4, hb3, hb2, hb1, hb0};

  hex_seg_scanner #(.LZ_SUPPRESS(1'b0)) dut_a (
    .ms_clk(ms_clk), .Reset_n(Reset_n), .enable(enable),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .HEX0(ha0), .HEX1(ha1), .HEX2(ha2), .HEX3(ha3), .HEX4(ha4), .HEX5(ha5),
    .frame_done(fd_a)
  );

  hex_seg_scanner #(.LZ_SUPPRESS(1'b1)) dut_b (
    .ms_clk(ms_clk), .Reset_n(Reset_n), .enable(enable),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
    .HEX0(hb0), .HEX1(hb1), .HEX2(hb2), .HEX3(hb3), .HEX4(hb4), .HEX5(hb5),
    .frame_done(fd_b)
  );

  initial ms_clk = 1'b0;
  always #5 ms_clk = ~ms_clk;

  typedef struct {
    int          frame;
    logic [41:0] ea;
    logic [41:0] eb;
  } sb_t;

  sb_t sb[$];
  int  vec_cnt   = 0;
  int  miss_cnt  = 0;
  int  frame_idx = 0;

  task automatic chk(input string nm, input logic [85:0] act, input logic [85:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Each frame_done pulse presents a finished frame; compare it if one is expected.
  always @(negedge ms_clk) begin
    sb_t ent;
    if (fd_a === 1'b1) begin
      frame_idx++;
      while (sb.size() > 0 && sb[0].frame < frame_idx) begin
        ent = sb.pop_front();
        vec_cnt++;
        miss_cnt++;
        $display("FAIL frame_missed: frame %0d passed without check, now at %0d", ent.frame, frame_idx);
      end
      if (sb.size() > 0 && sb[0].frame == frame_idx) begin
        ent = sb.pop_front();
        chk("frame", {fd_a, fd_b, hx_b, hx_a}, {1'b1, 1'b1, ent.eb, ent.ea});
      end
    end
  end

  task automatic step(input int unsigned k);
    repeat (k) begin
      @(negedge ms_clk);
      #1;
    end
  endtask

  task automatic set_d(input logic [23:0] v);
    {d5, d4, d3, d2, d1, d0} = v;
  endtask

  task automatic push(input int fr, input logic [41:0] ea, input logic [41:0] eb);
    sb_t e;
    e.frame = fr;
    e.ea    = ea;
    e.eb    = eb;
    sb.push_back(e);
  endtask

  // Returns just before a snapshot edge (frame_done high).
  task automatic wait_frame(output int n);
    int unsigned guard;
    guard = 0;
    do begin
      step(1);
      guard++;
    end while (fd_a !== 1'b1 && guard < 20);
    if (fd_a !== 1'b1) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL wait_frame: frame_done=%b expected 1 within 20 cycles", fd_a);
    end
    n = frame_idx;
  endtask

  task automatic run_frame(input logic [23:0] v, input logic [41:0] ea, input logic [41:0] eb);
    int n;
    set_d(v);
    wait_frame(n);
    push(n + 1, ea, eb);
    step(1);
  endtask

  function automatic logic [41:0] mix(input logic [41:0] nw, input logic [41:0] od, input int j);
    logic [41:0] r;
    for (int k = 0; k < 6; k++) r[k*7 +: 7] = (k < j) ? nw[k*7 +: 7] : od[k*7 +: 7];
    return r;
  endfunction

  initial begin
    int n;
    logic [41:0] nw, pa, pb;
    Reset_n = 1'b1;
    enable  = 1'b1;
    set_d(24'h000000);
    #2 Reset_n = 1'b0;
    step(3);
    chk("reset_state", {fd_a, fd_b, hx_b, hx_a}, {2'b00, ALL_BL, ALL_BL});
    Reset_n = 1'b1;

    // All zeros after release: cadence of frame_done and first full frame.
    for (int cyc = 1; cyc <= 21; cyc++) begin
      step(1);
      chk("fd_cadence", {84'd0, fd_a, fd_b}, {84'd0, (cyc % 7 == 0), (cyc % 7 == 0)});
      if (cyc == 1) chk("first_snap_only", {fd_a, fd_b, hx_b, hx_a}, {2'b00, ALL_BL, ALL_BL});
      if (cyc == 7) chk("zero_frame", {fd_a, fd_b, hx_b, hx_a},
                        {2'b11, {BL, BL, BL, BL, BL, S0}, {S0, S0, S0, S0, S0, S0}});
    end

    // Per-digit write timing: HEX k updates on edge E+k+1.
    set_d(24'h654321);
    nw = {S6, S5, S4, S3, S2, S1};
    push(frame_idx + 1, nw, nw);
    pa = {S0, S0, S0, S0, S0, S0};
    pb = {BL, BL, BL, BL, BL, S0};
    for (int j = 0; j <= 6; j++) begin
      step(1);
      chk("digit_timing", {fd_a, fd_b, hx_b, hx_a},
          {(j == 6), (j == 6), mix(nw, pb, j), mix(nw, pa, j)});
    end

    // Decode and leading-zero suppression patterns.
    run_frame(24'hF00042, {BL, S0, S0, S0, S4, S2}, {BL, BL, BL, BL, S4, S2});
    run_frame(24'h000000, {S0, S0, S0, S0, S0, S0}, {BL, BL, BL, BL, BL, S0});
    run_frame(24'h0300F0, {S0, S3, S0, S0, BL, S0}, {BL, S3, S0, S0, BL, S0});
    run_frame(24'hEDCBA9, {SE, SD, SC, SB, SA, S9}, {SE, SD, SC, SB, SA, S9});
    run_frame(24'h00000F, {S0, S0, S0, S0, S0, BL}, ALL_BL);
    run_frame(24'h100000, {S1, S0, S0, S0, S0, S0}, {S1, S0, S0, S0, S0, S0});
    run_frame(24'h780000, {S7, S8, S0, S0, S0, S0}, {S7, S8, S0, S0, S0, S0});

    // Input change at ph=3 waits for the next snapshot.
    set_d(24'h000000);
    wait_frame(n);
    push(n + 1, {S0, S0, S0, S0, S0, S0}, {BL, BL, BL, BL, BL, S0});
    step(3);
    set_d(24'hFFFFFF);
    push(n + 2, ALL_BL, ALL_BL);
    wait_frame(n);
    step(1);

    // Enable dropped at ph=4 for 5 cycles, then no stretching of frame_done.
    set_d(24'h123456);
    nw = {S1, S2, S3, S4, S5, S6};
    wait_frame(n);
    push(n + 1, nw, nw);
    step(4);
    enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step(1);
      chk("enable_hold", {fd_a, fd_b, hx_b, hx_a}, {2'b00, mix(nw, ALL_BL, 3), mix(nw, ALL_BL, 3)});
    end
    enable = 1'b1;
    for (int j = 4; j <= 6; j++) begin
      step(1);
      chk("enable_resume", {fd_a, fd_b, hx_b, hx_a},
          {(j == 6), (j == 6), mix(nw, ALL_BL, j), mix(nw, ALL_BL, j)});
    end
    enable = 1'b0;
    step(1);
    chk("fd_no_stretch", {fd_a, fd_b, hx_b, hx_a}, {2'b00, nw, nw});
    enable = 1'b1;

    // Reset at ph=2 blanks immediately; restart snapshots on first enabled edge.
    wait_frame(n);
    step(2);
    Reset_n = 1'b0;
    #1;
    chk("async_reset", {fd_a, fd_b, hx_b, hx_a}, {2'b00, ALL_BL, ALL_BL});
    step(1);
    set_d(24'h024680);
    Reset_n = 1'b1;
    step(1);
    chk("post_reset_e1", {fd_a, fd_b, hx_b, hx_a}, {2'b00, ALL_BL, ALL_BL});
    step(1);
    chk("post_reset_e2", {fd_a, fd_b, hx_b, hx_a},
        {2'b00, {BL, BL, BL, BL, BL, S0}, {BL, BL, BL, BL, BL, S0}});
    step(5);
    chk("post_reset_frame", {fd_a, fd_b, hx_b, hx_a},
        {2'b11, {BL, S2, S4, S6, S8, S0}, {S0, S2, S4, S6, S8, S0}});

    for (int g = 0; g < 100 && sb.size() > 0; g++) step(1);
    while (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      vec_cnt++;
      miss_cnt++;
      $display("FAIL sb_drain: frame %0d never presented, expected pending count 0", e.frame);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
